// File: rtl/if_id_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_id_fetch_queue
//
// Purpose:
//   Decoupling queue between the instruction fetch stage and the decode stage
//   of the five-stage MIPS pipeline. Fetched {pc, instruction} pairs are
//   buffered in program order. The oldest pair is offered to decode through a
//   valid/ready handshake. A flush drops everything that is buffered, for
//   example on a taken branch or jump redirect. Each entry also carries a flag
//   that marks a misaligned fetch PC (AdEL) for the exception path.
//
// Ports:
//   clk        rising-edge clock for all state
//   rstn       asynchronous active-low reset
//   flush      discard all entries and any same-cycle push
//   in_valid   fetch presents a valid pair
//   in_ready   queue can accept a pair this cycle
//   in_pc      PC of the fetched instruction
//   in_inst    fetched instruction word
//   out_valid  head entry is valid
//   out_ready  decode consumes the head this cycle
//   out_pc     PC of the head entry (0 when empty)
//   out_inst   instruction of the head entry (0 when empty)
//   out_adel   head entry's PC was not word aligned (0 when empty)
//   count      number of occupied entries
// ---------------------------------------------------------------------------
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_adel,
    output logic [PTR_W:0]   count
);

    // Entry storage. It is left unreset because an entry is never read
    // until a push has written it.
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic        mem_adel [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic pop;

    // Handshake status comes straight from the registered count. in_ready
    // does not look at out_ready, so a full queue only reopens one cycle
    // after it is popped.
    always_comb begin
        in_ready  = (count != (PTR_W+1)'(DEPTH));
        out_valid = (count != '0);
    end

    // Flush overrides both transfers, so neither pointer nor count moves
    // because of a transfer in the flush cycle.
    always_comb begin
        push = in_valid && in_ready && !flush;
        pop  = out_valid && out_ready && !flush;
    end

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap modulo DEPTH by natural overflow. A flush rewinds both
    // pointers to the origin and empties the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // Entry write. The misalignment tag is computed on the way in, so the
    // exception logic sees it together with the PC at the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= in_pc;
            mem_inst[wr_ptr] <= in_inst;
            mem_adel[wr_ptr] <= (in_pc[1:0] != 2'b00);
        end
    end

    // Head presentation. An empty queue shows an all-zero word at PC 0, so
    // decode sees a harmless NOP instead of stale storage.
    always_comb begin
        out_pc   = out_valid ? mem_pc[rd_ptr]   : 32'h0;
        out_inst = out_valid ? mem_inst[rd_ptr] : 32'h0;
        out_adel = out_valid ? mem_adel[rd_ptr] : 1'b0;
    end

endmodule
